mac_operand_feeder: RTL and testbench

Upstream operand stage for the 4-bit multiply-accumulate datapath. It buffers incoming (A, B) operand pairs in a small FIFO behind a valid/ready handshake. It issues them one at a time to the MAC as a single-cycle load pulse with stable operands, and waits for the MAC's done pulse before issuing the next pair. It also counts completed operations and flags a sticky error if the MAC fails to respond within a bounded time.

---
 rtl/mac_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/mac_operand_feeder.sv | 131 +++++++++++++
 tb/tb_mac_operand_feeder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------
// mac_pkg : shared widths, defaults and FSM state type for the MAC feeder
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package mac_pkg;

   localparam int OPERAND_W       = 4;
   localparam int ACC_W           = 8;
   localparam int DEFAULT_DEPTH   = 4;
   localparam int DEFAULT_TIMEOUT = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------
// sync_fifo : single-clock FIFO with head-of-queue read and occupancy count
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign w_push = push_i && !full_o;
   assign w_pop  = pop_i && !empty_o;

   // Storage carries no reset; validity is tracked entirely by count_q.
   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_operand_feeder.sv
// ----------------------------------------------------------------------
// mac_operand_feeder : queues operand pairs and issues them to the MAC
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module mac_operand_feeder
   import mac_pkg::*;
#(
   parameter  int DEPTH   = DEFAULT_DEPTH,
   parameter  int TIMEOUT = DEFAULT_TIMEOUT,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OPERAND_W-1:0] in_a,
   input  logic [OPERAND_W-1:0] in_b,
   output logic                 mac_load,
   output logic [OPERAND_W-1:0] mac_a,
   output logic [OPERAND_W-1:0] mac_b,
   input  logic                 mac_done,
   output logic                 busy,
   output logic [CNT_W-1:0]     count,
   output logic [ACC_W-1:0]     ops_done,
   output logic                 err
);

   localparam int FIFO_W = 2 * OPERAND_W;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t                 state_q;
   logic                   mac_load_q;
   logic                   busy_q;
   logic [OPERAND_W-1:0]   mac_a_q;
   logic [OPERAND_W-1:0]   mac_b_q;
   logic [WAIT_W-1:0]      wait_cnt_q;
   logic [ACC_W-1:0]       ops_done_q;
   logic                   err_q;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic [FIFO_W-1:0]      w_head;

   assign in_ready = !w_full;
   assign w_push   = in_valid && in_ready && !rst;
   assign w_pop    = !rst && !w_empty &&
                     ((state_q == IDLE) || ((state_q == WAIT) && mac_done));

   sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .din_i   ({in_a, in_b}),
      .dout_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mac_load_q <= 1'b0;
         busy_q     <= 1'b0;
         mac_a_q    <= '0;
         mac_b_q    <= '0;
         wait_cnt_q <= '0;
         ops_done_q <= '0;
         err_q      <= 1'b0;
      end else begin
         mac_load_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (w_pop) begin
                  state_q    <= ISSUE;
                  mac_load_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            ISSUE: begin
               wait_cnt_q <= '0;
               state_q    <= WAIT;
            end
            WAIT: begin
               // A done arriving in the final allowed cycle still wins over the timeout.
               if (mac_done) begin
                  ops_done_q <= ops_done_q + ACC_W'(1);
                  if (w_pop) begin
                     state_q    <= ISSUE;
                     mac_load_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
         if (w_pop) begin
            {mac_a_q, mac_b_q} <= w_head;
         end
      end
   end

   assign mac_load = mac_load_q;
   assign busy     = busy_q;
   assign mac_a    = mac_a_q;
   assign mac_b    = mac_b_q;
   assign ops_done = ops_done_q;
   assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
// ----------------------------------------------------------------------
// tb_mac_operand_feeder : randomized bench against a queue-based reference
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_mac_operand_feeder;
   import mac_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [OPERAND_W-1:0] in_a;
   logic [OPERAND_W-1:0] in_b;
   logic                 mac_load;
   logic [OPERAND_W-1:0] mac_a;
   logic [OPERAND_W-1:0] mac_b;
   logic                 mac_done;
   logic                 busy;
   logic [CNT_W-1:0]     count;
   logic [ACC_W-1:0]     ops_done;
   logic                 err;

   mac_operand_feeder #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .mac_load (mac_load),
      .mac_a    (mac_a),
      .mac_b    (mac_b),
      .mac_done (mac_done),
      .busy     (busy),
      .count    (count),
      .ops_done (ops_done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference: pending pairs, plus the one operation in flight (if any) and the cycle its load pulse occupies.
   logic [7:0]  m_q[$];
   bit          m_have = 1'b0;
   int          m_load = 0;
   logic [3:0]  m_a    = '0;
   logic [3:0]  m_b    = '0;
   logic [7:0]  m_ops  = '0;
   bit          m_err  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit         do_pop;
      bit         acc;
      logic [7:0] p;
      if (rst) begin
         m_q.delete();
         m_have = 1'b0;
         m_a    = '0;
         m_b    = '0;
         m_ops  = '0;
         m_err  = 1'b0;
      end else begin
         acc    = in_valid && (m_q.size() != DEPTH);
         do_pop = 1'b0;
         if (m_have) begin
            if (cyc > m_load) begin
               if (mac_done) begin
                  m_ops  = m_ops + 8'd1;
                  m_have = 1'b0;
                  do_pop = (m_q.size() > 0);
               end else if (cyc == m_load + TIMEOUT) begin
                  m_err  = 1'b1;
                  m_have = 1'b0;
               end
            end
         end else begin
            do_pop = (m_q.size() > 0);
         end
         if (do_pop) begin
            p      = m_q.pop_front();
            m_a    = p[7:4];
            m_b    = p[3:0];
            m_have = 1'b1;
            m_load = cyc + 1;
         end
         if (acc) begin
            m_q.push_back({in_a, in_b});
         end
      end
   endtask

   task automatic step(input bit v, input logic [3:0] a, input logic [3:0] b,
                       input bit d, input bit r);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      mac_done = d;
      rst      = r;
      @(negedge clk);
      check("count",    32'(count),    32'(m_q.size()));
      check("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
      check("mac_load", 32'(mac_load), 32'(m_have && (cyc == m_load)));
      check("busy",     32'(busy),     32'(m_have));
      check("mac_a",    32'(mac_a),    32'(m_a));
      check("mac_b",    32'(mac_b),    32'(m_b));
      check("ops_done", 32'(ops_done), 32'(m_ops));
      check("err",      32'(err),      32'(m_err));
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic rstep(input int pv, input int pd, input int pr);
      step($urandom_range(99) < pv, 4'($urandom), 4'($urandom),
           $urandom_range(99) < pd, $urandom_range(99) < pr);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      mac_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, then one pair (3,5) with a 3-cycle MAC
      step(0, 4'd0, 4'd0, 0, 1);
      step(0, 4'd0, 4'd0, 0, 0);
      step(1, 4'd3, 4'd5, 0, 0);
      repeat (4) step(0, 4'd0, 4'd0, 0, 0);
      step(0, 4'd0, 4'd0, 1, 0);
      repeat (3) step(0, 4'd0, 4'd0, 0, 0);

      // Fill past DEPTH with the MAC stalled, then drain
      for (int i = 0; i < 7; i++) step(1, 4'(i + 1), 4'(9 - i), 0, 0);
      repeat (20) step(0, 4'd0, 4'd0, 1, 0);

      // Back-to-back with done every cycle
      for (int i = 0; i < 3; i++) step(1, 4'(i + 4), 4'(i + 10), 1, 0);
      repeat (12) step(0, 4'd0, 4'd0, 1, 0);

      // Timeout with a queued follower; err must stay set
      step(1, 4'd7, 4'd2, 0, 0);
      step(1, 4'd6, 4'd1, 0, 0);
      repeat (TIMEOUT + 6) step(0, 4'd0, 4'd0, 0, 0);
      repeat (6) step(0, 4'd0, 4'd0, 1, 0);

      // Reset in WAIT with entries queued, then a stray done
      step(1, 4'd1, 4'd1, 0, 0);
      step(1, 4'd2, 4'd2, 0, 0);
      step(1, 4'd3, 4'd3, 0, 0);
      repeat (3) step(0, 4'd0, 4'd0, 0, 0);
      step(0, 4'd0, 4'd0, 0, 1);
      step(0, 4'd0, 4'd0, 1, 0);
      repeat (3) step(0, 4'd0, 4'd0, 0, 0);

      // Random mixes: occasional reset, timeouts, then a long run past the 8-bit wrap
      repeat (600)  rstep(50, 25, 2);
      repeat (150)  rstep(40, 0, 0);
      repeat (5)    rstep(0, 0, 100);
      repeat (1100) rstep(90, 100, 0);
      repeat (1500) rstep(60, 40, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
